vga_timing_gen: RTL and testbench

Parametrised raster timing generator for the display pipeline. It produces horizontal/vertical sync, data-enable, line/frame strobes, a frame counter and an early data-enable for memory prefetch, all from an externally supplied pixel clock. All video timings and sync polarities are set by parameters, so any progressive mode is handled without RTL edits. It sits between the pixel-clock generator and the pattern, character and frame-buffer readers.

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Counters plus registered sync/enable/strobe flags.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned LEAD     = 2,
  parameter int unsigned CW       = 11,
  parameter int unsigned FCW      = 8
) (
  input  logic           PCK,
  input  logic           RST,
  input  logic           EN,
  output logic           HS,
  output logic           VS,
  output logic           DE,
  output logic           DE_LEAD,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic [CW-1:0]  HCNT,
  output logic [CW-1:0]  VCNT,
  output logic [FCW-1:0] FRAME_CNT
);

  localparam int unsigned HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] HMAX = CW'(HT - 1);
  localparam logic [CW-1:0] VMAX = CW'(VT - 1);
  localparam logic [CW-1:0] HA   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VA   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS0  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS1  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS0  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS1  = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] HLA  = CW'(H_ACTIVE - LEAD);
  localparam logic [CW-1:0] HLB  = CW'(HT - LEAD);

  logic [CW-1:0]  hcnt_q, hcnt_d;
  logic [CW-1:0]  vcnt_q, vcnt_d;
  logic [CW-1:0]  vnext_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           de_q, de_d;
  logic           dl_q, dl_d;
  logic           ls_q, ls_d;
  logic           fs_q, fs_d;
  logic           h_wrap, v_wrap;

  // Next pixel position and the flags that describe it.
  always_comb begin
    h_wrap  = (hcnt_q == HMAX);
    v_wrap  = (vcnt_q == VMAX);
    hcnt_d  = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      if (v_wrap) fcnt_d = fcnt_q + 1'b1;
    end
    vnext_d = (vcnt_d == VMAX) ? '0 : vcnt_d + 1'b1;
    de_d    = (hcnt_d < HA) && (vcnt_d < VA);
    hs_d    = (hcnt_d >= HS0 && hcnt_d < HS1) ? HS_POL : ~HS_POL;
    vs_d    = (vcnt_d >= VS0 && vcnt_d < VS1) ? VS_POL : ~VS_POL;
    ls_d    = (hcnt_d == '0);
    fs_d    = (hcnt_d == '0) && (vcnt_d == '0);
    if (LEAD == 0) dl_d = de_d;
    else dl_d = ((vcnt_d < VA) && (hcnt_d < HLA)) ||
                ((hcnt_d >= HLB) && (vnext_d < VA));
  end

  // State update; reset parks on the last pixel of the frame.
  always_ff @(posedge PCK) begin
    if (RST) begin
      hcnt_q <= HMAX;
      vcnt_q <= VMAX;
      fcnt_q <= '1;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      dl_q   <= (LEAD > 0);
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else if (EN) begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fcnt_q <= fcnt_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      dl_q   <= dl_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign FRAME_CNT   = fcnt_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign DE          = de_q;
  assign DE_LEAD     = dl_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench on a 16x9 toy mode.
// HS active-low, VS active-high, LEAD=2, 3-bit frame counter.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int LD = 2;
  localparam int FRM = HT * VT;

  logic       PCK = 1'b0;
  logic       RST = 1'b1;
  logic       EN  = 1'b1;
  logic       HS, VS, DE, DE_LEAD, LINE_START, FRAME_START;
  logic [5:0] HCNT, VCNT;
  logic [2:0] FRAME_CNT;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .LEAD(LD), .CW(6), .FCW(3)
  ) dut (
    .PCK(PCK), .RST(RST), .EN(EN),
    .HS(HS), .VS(VS), .DE(DE), .DE_LEAD(DE_LEAD),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START),
    .HCNT(HCNT), .VCNT(VCNT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 PCK = ~PCK;

  function automatic logic [20:0] got();
    return {FRAME_CNT, VCNT, HCNT, FRAME_START, LINE_START,
            DE_LEAD, DE, VS, HS};
  endfunction

  // Expected outputs for the k-th pixel after the first frame start.
  function automatic logic [20:0] model(int k);
    int h, v, f, nl;
    logic de, hs, vs, dl, ls, fs;
    h  = k % HT;
    v  = (k / HT) % VT;
    f  = (k / FRM) % 8;
    nl = (v == VT - 1) ? 0 : v + 1;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HSW) ? 1'b0 : 1'b1;
    vs = (v >= VA + VF && v < VA + VF + VSW) ? 1'b1 : 1'b0;
    dl = ((v < VA) && (h < HA - LD)) || ((h >= HT - LD) && (nl < VA));
    ls = (h == 0);
    fs = (h == 0) && (v == 0);
    return {3'(f), 6'(v), 6'(h), fs, ls, dl, de, vs, hs};
  endfunction

  task automatic chk(input string tag, input logic [20:0] obs,
                     input logic [20:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCK);
    #1;
  endtask

  // Hand-derived {FS,LS,DL,DE,VS,HS} at chosen offsets into frame 0.
  int         dk[15] = '{0, 5, 6, 8, 10, 12, 13, 14, 53, 62,
                          79, 80, 111, 112, 142};
  logic [5:0] dv[15] = '{6'b111101, 6'b001101, 6'b000101, 6'b000001,
                         6'b000000, 6'b000000, 6'b000001, 6'b001001,
                         6'b001101, 6'b000001, 6'b000001, 6'b010011,
                         6'b000011, 6'b010001, 6'b001001};

  localparam logic [20:0] RST_V = {3'd7, 6'd8, 6'd15, 6'b001001};
  localparam logic [20:0] FS0_V = {3'd0, 6'd0, 6'd0, 6'b111101};

  initial begin
    int kk;
    logic [20:0] prev;
    bit found;

    repeat (3) step();
    chk("reset", got(), RST_V);

    RST = 1'b0;
    for (int k = 0; k < FRM * 8 + 8; k++) begin
      step();
      chk("run", got(), model(k));
      for (int i = 0; i < 15; i++)
        if (k == dk[i]) chk("dir", got(), {FRAME_CNT, VCNT, HCNT, dv[i]});
      if (k == 0) chk("first", got(), FS0_V);
      if (k == FRM)
        chk("frame1", got(), {3'd1, 6'd0, 6'd0, 6'b111101});
      if (k == FRM * 8)
        chk("fwrap", got(), {3'd0, 6'd0, 6'd0, 6'b111101});
    end
    kk = FRM * 8 + 8;

    prev = got();
    for (int c = 0; c < 2 * FRM * 2; c++) begin
      EN = 1'($urandom_range(0, 1));
      step();
      if (EN) begin
        chk("en_run", got(), model(kk));
        kk++;
      end else begin
        chk("en_hold", got(), prev);
      end
      prev = got();
    end

    EN = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2 * FRM && !found; c++) begin
      step();
      if (HCNT == 6'd11 && VCNT == 6'd6) found = 1'b1;
    end
    chk("seek", {20'd0, found}, 21'd1);
    chk("seek_hv", got(), {FRAME_CNT, 6'd6, 6'd11, 6'b000010});

    RST = 1'b1;
    EN  = 1'b0;
    step();
    chk("mid_rst", got(), RST_V);
    RST = 1'b0;
    EN  = 1'b1;
    step();
    chk("post_rst", got(), FS0_V);
    step();
    chk("post_rst1", got(), model(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
